spi_shift_engine: RTL and testbench

//  Byte-level SPI master (mode 0, MSB first) downstream of the APB-to-SPI NOR flash controller.

---
 rtl/spi_shift_engine.sv | 177 +++++++++++++++++
 tb/tb_spi_shift_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Byte-level SPI mode-0 master, MSB first, chip select held
//               across multi-byte flash commands.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       s_clk,
    output logic       s_css,
    output logic       s_mosi,
    input  logic       s_miso
);

    localparam int c_cnt_max = (CLK_DIV > CS_SETUP) ?
                               ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                               ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_div_load   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'(CS_SETUP - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load  = c_cnt_w'(CS_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_setup = 3'd1;
    localparam logic [2:0] c_shift = 3'd2;
    localparam logic [2:0] c_wait  = 3'd3;
    localparam logic [2:0] c_hold  = 3'd4;

    logic [2:0]         r_state, w_state_next;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic [3:0]         r_tog, w_tog_next;
    logic [6:0]         r_tx_shift, w_tx_shift_next;
    logic [7:0]         r_rx_shift, w_rx_shift_next;
    logic [7:0]         r_rx_data, w_rx_data_next;
    logic               r_rx_valid, w_rx_valid_next;
    logic               r_last, w_last_next;
    logic               r_s_clk, w_s_clk_next;
    logic               r_s_mosi, w_s_mosi_next;
    logic               r_s_css;
    logic               r_busy;
    logic               w_tick;
    logic               w_accept;
    logic               w_ready;

    assign w_ready  = ((r_state == c_idle) || (r_state == c_wait)) && !p_reset;
    assign w_accept = tx_valid && w_ready;
    assign w_tick   = (r_cnt == '0);

    assign tx_ready = w_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign s_clk    = r_s_clk;
    assign s_css    = r_s_css;
    assign s_mosi   = r_s_mosi;

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_next = c_setup;
            c_setup: if (w_tick)   w_state_next = c_shift;
            c_shift: begin
                // r_tog == 15 on a tick is the 8th falling edge of the byte
                if (w_tick && (r_tog == 4'd15)) begin
                    w_state_next = r_last ? c_hold : c_wait;
                end
            end
            c_wait:  if (w_accept) w_state_next = c_shift;
            c_hold:  if (w_tick)   w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        w_cnt_next      = r_cnt;
        w_tog_next      = r_tog;
        w_tx_shift_next = r_tx_shift;
        w_rx_shift_next = r_rx_shift;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_last_next     = r_last;
        w_s_clk_next    = r_s_clk;
        w_s_mosi_next   = r_s_mosi;
        case (r_state)
            c_idle, c_wait: begin
                if (w_accept) begin
                    w_cnt_next      = (r_state == c_idle) ? c_setup_load : c_div_load;
                    w_tog_next      = 4'd0;
                    w_tx_shift_next = tx_data[6:0];
                    w_s_mosi_next   = tx_data[7];
                    w_last_next     = tx_last;
                    w_s_clk_next    = 1'b0;
                end
            end
            c_setup: begin
                w_cnt_next = w_tick ? c_div_load : (r_cnt - c_cnt_one);
            end
            c_shift: begin
                if (w_tick) begin
                    w_cnt_next   = c_div_load;
                    w_s_clk_next = !r_s_clk;
                    w_tog_next   = r_tog + 4'd1;
                    if (!r_s_clk) begin
                        w_rx_shift_next = {r_rx_shift[6:0], s_miso};
                    end else if (r_tog == 4'd15) begin
                        w_rx_data_next  = r_rx_shift;
                        w_rx_valid_next = 1'b1;
                        w_cnt_next      = c_hold_load;
                    end else begin
                        w_s_mosi_next   = r_tx_shift[6];
                        w_tx_shift_next = {r_tx_shift[5:0], 1'b0};
                    end
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end
            c_hold: begin
                if (!w_tick) w_cnt_next = r_cnt - c_cnt_one;
            end
            default: ;
        endcase
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            r_cnt      <= '0;
            r_tog      <= 4'd0;
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_s_clk    <= 1'b0;
            r_s_mosi   <= 1'b0;
            r_s_css    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_tog      <= w_tog_next;
            r_tx_shift <= w_tx_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_last     <= w_last_next;
            r_s_clk    <= w_s_clk_next;
            r_s_mosi   <= w_s_mosi_next;
            // Chip select and busy track the state they will be in next cycle
            r_s_css    <= (w_state_next == c_idle);
            r_busy     <= (w_state_next != c_idle);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Directed self-checking bench for spi_shift_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

    logic p_clk   = 1'b0;
    logic p_reset = 1'b1;
    always #5 p_clk = ~p_clk;

    // DUT A: CLK_DIV=2
    logic [7:0] tx_data_a  = 8'h00;
    logic       tx_valid_a = 1'b0;
    logic       tx_last_a  = 1'b0;
    logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, css_a, mosi_a;
    logic [7:0] rx_data_a;
    logic       miso_a = 1'b0;

    // DUT 1: CLK_DIV=1
    logic [7:0] tx_data_1  = 8'h00;
    logic       tx_valid_1 = 1'b0;
    logic       tx_last_1  = 1'b0;
    logic       tx_ready_1, rx_valid_1, busy_1, sclk_1, css_1, mosi_1;
    logic [7:0] rx_data_1;
    logic       miso_1 = 1'b0;

    spi_shift_engine #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .p_clk(p_clk), .p_reset(p_reset),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_last(tx_last_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .busy(busy_a), .s_clk(sclk_a), .s_css(css_a), .s_mosi(mosi_a),
        .s_miso(miso_a)
    );

    spi_shift_engine #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
        .p_clk(p_clk), .p_reset(p_reset),
        .tx_data(tx_data_1), .tx_valid(tx_valid_1), .tx_last(tx_last_1),
        .tx_ready(tx_ready_1), .rx_data(rx_data_1), .rx_valid(rx_valid_1),
        .busy(busy_1), .s_clk(sclk_1), .s_css(css_1), .s_mosi(mosi_1),
        .s_miso(miso_1)
    );

    int checks = 0;
    int errors = 0;

    // Flash model and monitors for DUT A
    logic [7:0] resp_a [0:7];
    int         ra_idx = 0;
    int         ra_bit = 0;
    logic [7:0] mosi_sh_a = 8'h00;
    logic [7:0] mosi_log_a [$];
    logic [7:0] rxq_a [$];
    int rises_a = 0, css_low_a = 0, css_rise_a = 0, bad_wait_a = 0, acc_a = 0;

    always @(negedge css_a) begin
        logic [7:0] cur;
        ra_bit = 0;
        cur    = resp_a[ra_idx];
        miso_a = cur[7];
    end
    always @(posedge sclk_a) begin
        mosi_sh_a = {mosi_sh_a[6:0], mosi_a};
        rises_a++;
        ra_bit++;
        if (ra_bit == 8) mosi_log_a.push_back(mosi_sh_a);
    end
    always @(negedge sclk_a) begin
        logic [7:0] cur;
        if (!css_a) begin
            if (ra_bit == 8) begin
                ra_bit = 0;
                if (ra_idx < 7) ra_idx++;
            end
            cur    = resp_a[ra_idx];
            miso_a = cur[7-ra_bit];
        end
    end
    always @(posedge css_a) css_rise_a++;
    always @(posedge p_clk) begin
        if (rx_valid_a) rxq_a.push_back(rx_data_a);
        if (!css_a) css_low_a++;
        if (tx_ready_a && sclk_a) bad_wait_a++;
        if (tx_valid_a && tx_ready_a) acc_a++;
    end

    // Flash model and monitors for DUT 1
    logic [7:0] resp_1 = 8'h00;
    int         rb_bit = 0;
    logic [7:0] mosi_sh_1 = 8'h00;
    logic [7:0] rxq_1 [$];
    int rises_1 = 0, css_low_1 = 0, cyc = 0, first_rise_1 = 0, last_rise_1 = 0;

    always @(negedge css_1) begin
        rb_bit = 0;
        miso_1 = resp_1[7];
    end
    always @(posedge sclk_1) begin
        mosi_sh_1 = {mosi_sh_1[6:0], mosi_1};
        if (rises_1 == 0) first_rise_1 = cyc;
        last_rise_1 = cyc;
        rises_1++;
        rb_bit++;
    end
    always @(negedge sclk_1) begin
        if (!css_1 && rb_bit < 8) miso_1 = resp_1[7-rb_bit];
    end
    always @(posedge p_clk) begin
        cyc++;
        if (rx_valid_1) rxq_1.push_back(rx_data_1);
        if (!css_1) css_low_1++;
    end

    task automatic clear_a();
        rises_a = 0; css_low_a = 0; css_rise_a = 0; bad_wait_a = 0; acc_a = 0;
        ra_idx = 0;
        mosi_log_a.delete();
        rxq_a.delete();
    endtask

    task automatic send_a(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge p_clk);
        while (!tx_ready_a && n < 1000) begin
            @(negedge p_clk);
            n++;
        end
        if (!tx_ready_a) begin
            checks++; errors++;
            $display("FAIL send_a_timeout: tx_ready=%b required 1", tx_ready_a);
        end
        tx_data_a = d; tx_last_a = last; tx_valid_a = 1'b1;
        @(negedge p_clk);
        tx_valid_a = 1'b0; tx_last_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 2000) begin
            @(negedge p_clk);
            n++;
        end
        if (busy_a) begin
            checks++; errors++;
            $display("FAIL wait_idle_a_timeout: busy=%b required 0", busy_a);
        end
        repeat (2) @(negedge p_clk);
    endtask

    task automatic test_reset();
        @(negedge p_clk);
        checks++;
        if ({css_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: css,clk,mosi,rxv,busy,rdy=%b required 100000",
                     {css_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a});
        end
        checks++;
        if (rx_data_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data_a);
        end
        p_reset = 1'b0;
        @(negedge p_clk);
        checks++;
        if (tx_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: rdy=%b busy=%b required 1 0", tx_ready_a, busy_a);
        end
    endtask

    task automatic test_single();
        clear_a();
        resp_a[0] = 8'h3C;
        send_a(8'hA5, 1'b1);
        wait_idle_a();
        checks++;
        if (rises_a != 8) begin errors++; $display("FAIL single_rises: got %0d required 8", rises_a); end
        checks++;
        if (mosi_log_a[0] !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h required a5", mosi_log_a[0]); end
        checks++;
        if (rxq_a.size() != 1) begin errors++; $display("FAIL single_rx_count: got %0d required 1", rxq_a.size()); end
        checks++;
        if (rxq_a[0] !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h required 3c", rxq_a[0]); end
        checks++;
        if (css_low_a != 36) begin errors++; $display("FAIL single_css_low: got %0d required 36", css_low_a); end
    endtask

    task automatic test_multi();
        logic [7:0] exp_rx [4];
        exp_rx = '{8'hFF, 8'hEF, 8'h40, 8'h18};
        clear_a();
        for (int i = 0; i < 4; i++) resp_a[i] = exp_rx[i];
        send_a(8'h9F, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b1);
        wait_idle_a();
        checks++;
        if (rises_a != 32) begin errors++; $display("FAIL multi_rises: got %0d required 32", rises_a); end
        checks++;
        if (css_rise_a != 1) begin errors++; $display("FAIL multi_css_rises: got %0d required 1", css_rise_a); end
        checks++;
        if (bad_wait_a != 0) begin errors++; $display("FAIL multi_sclk_ready: got %0d required 0", bad_wait_a); end
        checks++;
        if (rxq_a.size() != 4) begin errors++; $display("FAIL multi_rx_count: got %0d required 4", rxq_a.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxq_a[i] !== exp_rx[i]) begin
                errors++; $display("FAIL multi_rx[%0d]: got %h required %h", i, rxq_a[i], exp_rx[i]);
            end
        end
        checks++;
        if (mosi_log_a[0] !== 8'h9F) begin errors++; $display("FAIL multi_mosi0: got %h required 9f", mosi_log_a[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] resp  [3];
        int idx  = 0;
        int prev = 0;
        bytes = '{8'h11, 8'h22, 8'h33};
        resp  = '{8'hAA, 8'hBB, 8'hCC};
        clear_a();
        for (int i = 0; i < 3; i++) resp_a[i] = resp[i];
        @(negedge p_clk);
        tx_data_a = bytes[0]; tx_last_a = 1'b0; tx_valid_a = 1'b1;
        for (int n = 0; n < 2000 && idx < 3; n++) begin
            @(negedge p_clk);
            if (acc_a != prev) begin
                prev = acc_a;
                idx++;
                if (idx < 3) begin
                    tx_data_a = bytes[idx];
                    tx_last_a = (idx == 2);
                end
            end
        end
        tx_valid_a = 1'b0; tx_last_a = 1'b0;
        wait_idle_a();
        checks++;
        if (acc_a != 3) begin errors++; $display("FAIL b2b_accepts: got %0d required 3", acc_a); end
        checks++;
        if (bad_wait_a != 0) begin errors++; $display("FAIL b2b_ready_in_shift: got %0d required 0", bad_wait_a); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rxq_a[i] !== resp[i] || mosi_log_a[i] !== bytes[i]) begin
                errors++;
                $display("FAIL b2b_byte[%0d]: rx %h mosi %h required %h %h",
                         i, rxq_a[i], mosi_log_a[i], resp[i], bytes[i]);
            end
        end
    endtask

    task automatic test_reset_midbyte();
        int n = 0;
        clear_a();
        resp_a[0] = 8'hE7;
        send_a(8'h96, 1'b1);
        while (rises_a < 3 && n < 500) begin
            @(negedge p_clk);
            n++;
        end
        #2 p_reset = 1'b1;
        #1;
        checks++;
        if ({css_a, sclk_a, busy_a, rx_valid_a, tx_ready_a} !== 5'b10000) begin
            errors++;
            $display("FAIL midreset_ctrl: css,clk,busy,rxv,rdy=%b required 10000",
                     {css_a, sclk_a, busy_a, rx_valid_a, tx_ready_a});
        end
        @(negedge p_clk);
        p_reset = 1'b0;
        repeat (3) @(negedge p_clk);
        checks++;
        if (rxq_a.size() != 0) begin errors++; $display("FAIL midreset_rx_valid: got %0d required 0", rxq_a.size()); end
        clear_a();
        resp_a[0] = 8'hC3;
        send_a(8'h5A, 1'b1);
        wait_idle_a();
        checks++;
        if (rxq_a.size() != 1 || rxq_a[0] !== 8'hC3) begin
            errors++; $display("FAIL midreset_recover_rx: got %h required c3", rxq_a[0]);
        end
        checks++;
        if (mosi_log_a[0] !== 8'h5A) begin errors++; $display("FAIL midreset_recover_mosi: got %h required 5a", mosi_log_a[0]); end
    endtask

    task automatic test_div1();
        int n = 0;
        rises_1 = 0; css_low_1 = 0; rxq_1.delete();
        resp_1 = 8'h7E;
        @(negedge p_clk);
        tx_data_1 = 8'h81; tx_last_1 = 1'b1; tx_valid_1 = 1'b1;
        @(negedge p_clk);
        tx_valid_1 = 1'b0; tx_last_1 = 1'b0;
        while (busy_1 && n < 500) begin
            @(negedge p_clk);
            n++;
        end
        repeat (2) @(negedge p_clk);
        checks++;
        if (css_low_1 != 20) begin errors++; $display("FAIL div1_css_low: got %0d required 20", css_low_1); end
        checks++;
        if (last_rise_1 - first_rise_1 != 14 || rises_1 != 8) begin
            errors++; $display("FAIL div1_rise_span: got %0d/%0d required 14/8", last_rise_1 - first_rise_1, rises_1);
        end
        checks++;
        if (rxq_1.size() != 1 || rxq_1[0] !== 8'h7E) begin errors++; $display("FAIL div1_rx: got %h required 7e", rxq_1[0]); end
        checks++;
        if (mosi_sh_1 !== 8'h81) begin errors++; $display("FAIL div1_mosi: got %h required 81", mosi_sh_1); end
    endtask

    task automatic test_wait_stall();
        int n = 0;
        clear_a();
        resp_a[0] = 8'h42;
        resp_a[1] = 8'h24;
        send_a(8'h0F, 1'b0);
        while (rxq_a.size() == 0 && n < 500) begin
            @(negedge p_clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge p_clk);
            checks++;
            if ({css_a, sclk_a, busy_a, tx_ready_a} !== 4'b0011) begin
                errors++;
                $display("FAIL stall_wait[%0d]: css,clk,busy,rdy=%b required 0011", i,
                         {css_a, sclk_a, busy_a, tx_ready_a});
            end
        end
        send_a(8'hF0, 1'b1);
        wait_idle_a();
        checks++;
        if (rxq_a[0] !== 8'h42 || rxq_a[1] !== 8'h24) begin
            errors++; $display("FAIL stall_rx: got %h %h required 42 24", rxq_a[0], rxq_a[1]);
        end
        checks++;
        if (mosi_log_a[1] !== 8'hF0 || css_rise_a != 1) begin
            errors++; $display("FAIL stall_mosi: got %h rises %0d required f0 1", mosi_log_a[1], css_rise_a);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp_a[i] = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_reset_midbyte();
        test_div1();
        test_wait_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
